// File: rtl/mem_wb_skid_register_pkg.sv
// Shared types for the Memory->Writeback pipeline register: the writeback
// bundle layout at default widths and the skid controller state encoding.
package mem_wb_skid_register_pkg;

    localparam int DEF_DATA_WIDTH     = 32;
    localparam int DEF_REG_ADDR_WIDTH = 5;

    typedef struct packed {
        logic [DEF_DATA_WIDTH-1:0]     readData;
        logic [DEF_DATA_WIDTH-1:0]     pcPlus4;
        logic [DEF_DATA_WIDTH-1:0]     aluOut;
        logic                          regWrite;
        logic                          resultSrc;
        logic                          storeNextPc;
        logic [DEF_REG_ADDR_WIDTH-1:0] rd;
    } mem_wb_bundle_t;

    typedef enum logic [1:0] {
        EMPTY,
        FULL,
        SKID
    } skid_state_t;

endpackage

// File: rtl/pipe_skid_ctrl.sv
// Handshake state machine for a two-entry skid register: decides when the
// main and skid bundle registers load and what the handshake outputs show.
module pipe_skid_ctrl
    import mem_wb_skid_register_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic validIn,
    input  logic readyOut,
    input  logic flush,
    output logic readyIn,
    output logic validOut,
    output logic loadMain,
    output logic loadSkid,
    output logic mainFromSkid
);

    skid_state_t state, stateNext;
    logic accept, drain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= EMPTY;
        else     state <= stateNext;
    end

    // Handshake outputs come from the registered state only, so upstream
    // ready never depends combinationally on downstream ready.
    always_comb begin
        stateNext    = state;
        loadMain     = 1'b0;
        loadSkid     = 1'b0;
        mainFromSkid = 1'b0;
        readyIn      = (state != SKID);
        validOut     = (state != EMPTY);
        accept       = validIn & readyIn;
        drain        = validOut & readyOut;

        if (flush) begin
            stateNext = EMPTY;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (accept) begin
                        stateNext = FULL;
                        loadMain  = 1'b1;
                    end
                end
                FULL: begin
                    if (accept && drain) begin
                        loadMain = 1'b1;
                    end else if (accept) begin
                        stateNext = SKID;
                        loadSkid  = 1'b1;
                    end else if (drain) begin
                        stateNext = EMPTY;
                    end
                end
                SKID: begin
                    if (drain) begin
                        stateNext    = FULL;
                        mainFromSkid = 1'b1;
                    end
                end
                default: stateNext = EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/mem_wb_skid_register.sv
// Memory->Writeback pipeline register with valid/ready handshake, one-deep
// overflow skid, flush, and x0-aware RegWrite gating.
module mem_wb_skid_register
    import mem_wb_skid_register_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int REG_ADDR_WIDTH  = 5,
    parameter bit NEGEDGE_CAPTURE = 1'b1,
    parameter bit SUPPRESS_X0     = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ValidM_i,
    output logic                      ReadyM_o,
    input  logic [DATA_WIDTH-1:0]     ReadDataM_i,
    input  logic [DATA_WIDTH-1:0]     PCPlus4M_i,
    input  logic [DATA_WIDTH-1:0]     ALU_outM_i,
    input  logic                      RegWriteM_i,
    input  logic                      ResultSrcM_i,
    input  logic                      StoreNextPCM_i,
    input  logic [REG_ADDR_WIDTH-1:0] RdM_i,
    input  logic                      FlushW_i,
    output logic                      ValidW_o,
    input  logic                      ReadyW_i,
    output logic [DATA_WIDTH-1:0]     ReadDataW_o,
    output logic [DATA_WIDTH-1:0]     PCPlus4W_o,
    output logic [DATA_WIDTH-1:0]     ALU_outW_o,
    output logic                      RegWriteW_o,
    output logic                      ResultSrcW_o,
    output logic                      StoreNextPCW_o,
    output logic [REG_ADDR_WIDTH-1:0] RdW_o
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0]     readData;
        logic [DATA_WIDTH-1:0]     pcPlus4;
        logic [DATA_WIDTH-1:0]     aluOut;
        logic                      regWrite;
        logic                      resultSrc;
        logic                      storeNextPc;
        logic [REG_ADDR_WIDTH-1:0] rd;
    } bundle_t;

    bundle_t incoming, mainReg, skidReg;
    logic    activeClk;
    logic    loadMain, loadSkid, mainFromSkid;

    // Falling-edge capture is done by inverting the clock feeding every flop.
    assign activeClk = NEGEDGE_CAPTURE ? ~clk : clk;

    assign incoming = '{
        readData:    ReadDataM_i,
        pcPlus4:     PCPlus4M_i,
        aluOut:      ALU_outM_i,
        regWrite:    RegWriteM_i,
        resultSrc:   ResultSrcM_i,
        storeNextPc: StoreNextPCM_i,
        rd:          RdM_i
    };

    pipe_skid_ctrl ctrl (
        .clk          (activeClk),
        .rst          (rst),
        .validIn      (ValidM_i),
        .readyOut     (ReadyW_i),
        .flush        (FlushW_i),
        .readyIn      (ReadyM_o),
        .validOut     (ValidW_o),
        .loadMain     (loadMain),
        .loadSkid     (loadSkid),
        .mainFromSkid (mainFromSkid)
    );

    always_ff @(posedge activeClk or posedge rst) begin
        if (rst)               mainReg <= '0;
        else if (loadMain)     mainReg <= incoming;
        else if (mainFromSkid) mainReg <= skidReg;
    end

    always_ff @(posedge activeClk or posedge rst) begin
        if (rst)           skidReg <= '0;
        else if (loadSkid) skidReg <= incoming;
    end

    assign ReadDataW_o    = mainReg.readData;
    assign PCPlus4W_o     = mainReg.pcPlus4;
    assign ALU_outW_o     = mainReg.aluOut;
    assign ResultSrcW_o   = mainReg.resultSrc;
    assign StoreNextPCW_o = mainReg.storeNextPc;
    assign RdW_o          = mainReg.rd;

    // Writes to x0 are architecturally dead, so the write enable is dropped here.
    assign RegWriteW_o = mainReg.regWrite & ValidW_o &
                         ~(SUPPRESS_X0 & (mainReg.rd == '0));

endmodule

// File: doc/mem_wb_skid_register.md
Name: mem_wb_skid_register

Overview:
- Parametrised Memory→Writeback pipeline register with a valid/ready handshake, a 2-entry skid buffer, flush and asynchronous reset.
- Carries the M-stage writeback bundle: read data, PC+4, ALU result, RegWrite, ResultSrc, StoreNextPC and Rd.
- Sits between the data-memory stage and the register-file write port.
- Lets a variable-latency memory or a stalled writeback port back-pressure the pipe without losing or duplicating instructions.

Parameters:
- DATA_WIDTH, 32, width of ReadData/PCPlus4/ALU_out fields.
- REG_ADDR_WIDTH, 5, width of Rd.
- NEGEDGE_CAPTURE, 1, 1 = state updates on falling clk edge (pipeline convention); 0 = rising edge.
- SUPPRESS_X0, 1, 1 = RegWriteW_o forced low when RdW_o == 0.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous active-high reset.
- ValidM_i  in  1  M-stage bundle valid.
- ReadyM_o  out  1  register can accept a bundle this edge.
- ReadDataM_i / PCPlus4M_i / ALU_outM_i  in  DATA_WIDTH each  payload.
- RegWriteM_i / ResultSrcM_i / StoreNextPCM_i  in  1 each  payload controls.
- RdM_i  in  REG_ADDR_WIDTH  destination register.
- FlushW_i  in  1  discard all held bundles.
- ValidW_o  out  1  W-stage bundle valid.
- ReadyW_i  in  1  writeback consumes the bundle this edge.
- ReadDataW_o / PCPlus4W_o / ALU_outW_o  out  DATA_WIDTH  registered payload.
- RegWriteW_o / ResultSrcW_o / StoreNextPCW_o  out  1  registered controls; RegWriteW_o is gated.
- RdW_o  out  REG_ADDR_WIDTH  registered destination.

Behaviour:
- One clock; reset is asynchronous and active-high on rst. All state updates occur on the active edge selected by NEGEDGE_CAPTURE.
- Reset (immediate, mid-operation included):
  - state = EMPTY, ValidW_o = 0, ReadyM_o = 1.
  - All payload outputs = 0, RegWriteW_o = 0.
  - Skid contents cleared to 0.
- Definitions:
  - accept = ValidM_i & ReadyM_o.
  - drain = ValidW_o & ReadyW_i.
- Storage:
  - main register drives the outputs directly; there is no output mux.
  - skid register holds one overflow bundle.
- States and outputs:
  - EMPTY: ValidW_o = 0, ReadyM_o = 1.
  - FULL: ValidW_o = 1, ReadyM_o = 1.
  - SKID: ValidW_o = 1, ReadyM_o = 0.
- Transitions (priority: rst > FlushW_i > handshake):
  - EMPTY: accept → FULL, main ← input; otherwise hold.
  - FULL, accept & drain → FULL, main ← input.
  - FULL, accept & !drain → SKID, skid ← input, main holds.
  - FULL, !accept & drain → EMPTY.
  - FULL, neither → hold.
  - SKID, drain → FULL, main ← skid. Input is ignored because ReadyM_o = 0.
  - SKID, !drain → hold.
  - FlushW_i sampled high → EMPTY, regardless of accept/drain. The bundle offered that edge is dropped, payload registers keep stale values, ValidW_o = 0.
- ReadyM_o is a function of registered state only; there is no combinational path from ReadyW_i or ValidM_i.
- Latency: 1 active edge from accept to ValidW_o. Throughput: 1 bundle per edge when ReadyW_i is held high.
- Ordering: strict FIFO order. Never drop a bundle except on flush. Never present the same bundle twice.
- RegWriteW_o = main.RegWrite & ValidW_o & !(SUPPRESS_X0 & RdW_o == 0).
- ResultSrcW_o and StoreNextPCW_o are not gated; consumers qualify them with ValidW_o.
- While ValidW_o = 1 and ReadyW_i = 0, all W outputs are stable.

Decomposition:
- Shared types package gains:
  - mem_wb_bundle_t: packed struct of the seven payload fields, sized by DATA_WIDTH/REG_ADDR_WIDTH defaults.
  - skid_state_t enum {EMPTY, FULL, SKID}.
- One sub-module: pipe_skid_ctrl. It holds the state machine and generates ReadyM_o, ValidW_o and the load_main/load_skid/main_from_skid enables. The top level instantiates it plus the two bundle registers and the RegWrite gating.

Test Plan:
- Reset: assert rst mid-cycle with state SKID → outputs immediately 0, ValidW_o = 0, ReadyM_o = 1; after release, first accepted bundle appears one edge later.
- Streaming: ReadyW_i = 1, push ALU_out 0x10, 0x20, 0x30 on consecutive edges → ValidW_o high for 3 edges, ALU_outW_o = 0x10, 0x20, 0x30 in order.
- Back-pressure: push 0xA, 0xB with ReadyW_i = 0 → state SKID, ReadyM_o = 0, output holds 0xA. Push 0xC held with ValidM_i high, then ReadyW_i = 1 → outputs 0xA, 0xB, 0xC with none lost or duplicated.
- Flush in SKID with ValidM_i = 1 → ValidW_o = 0 and ReadyM_o = 1 next edge; the flushed bundles and the offered bundle never appear.
- x0 gating: RegWriteM_i = 1, RdM_i = 0 → RegWriteW_o = 0. Repeat with RdM_i = 5 → RegWriteW_o = 1. Repeat with SUPPRESS_X0 = 0 and RdM_i = 0 → RegWriteW_o = 1.
- Edge mode: NEGEDGE_CAPTURE = 0 → state changes only on rising clk; NEGEDGE_CAPTURE = 1 → only on falling clk.
